// File: rtl/usr_seq_shifter.sv
// usr_seq_shifter
//
// WIDTH-bit universal shift register with a built-in step sequencer. One
// start strobe issues a whole multi-position shift or rotate; the register
// then moves one bit position per clock until the command completes.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start; single-edge ops and the first step happen here
//   BUSY  | multi-step command running, one step per edge
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset, clears all state
//   start       command strobe, accepted only in IDLE
//   mode        operation (latched on accept)
//                 000 hold, 001 SLL, 010 SRL, 011 load, 100 ROL, 101 ROR,
//                 110 ASR, 111 reserved (hold)
//   amount      number of 1-bit steps (latched on accept)
//   abort       synchronous cancel of a running command
//   d           parallel load data
//   ser_in_lsb  fill bit entering q[0] on SLL
//   ser_in_msb  fill bit entering q[WIDTH-1] on SRL
//   q           register contents
//   busy        command in progress (registered)
//   done        one-cycle completion pulse (registered)
//   sout_msb    q[WIDTH-1]
//   sout_lsb    q[0]

module usr_seq_shifter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic             abort,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_lsb,
    input  logic             ser_in_msb,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             sout_msb,
    output logic             sout_lsb
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SLL  = 3'b001;
    localparam logic [2:0] M_SRL  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // One bit-position move of the register for the given mode. Fill bits
    // come straight from the pins so they are sampled on every step edge.
    function automatic logic [WIDTH-1:0] step_once(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] v,
        input logic             fill_lsb,
        input logic             fill_msb
    );
        case (m)
            M_SLL:   step_once = {v[WIDTH-2:0], fill_lsb};
            M_SRL:   step_once = {fill_msb, v[WIDTH-1:1]};
            M_ROL:   step_once = {v[WIDTH-2:0], v[WIDTH-1]};
            M_ROR:   step_once = {v[0], v[WIDTH-1:1]};
            M_ASR:   step_once = {v[WIDTH-1], v[WIDTH-1:1]};
            default: step_once = v;
        endcase
    endfunction

    function automatic logic is_step_mode(input logic [2:0] m);
        case (m)
            M_SLL, M_SRL, M_ROL, M_ROR, M_ASR: is_step_mode = 1'b1;
            default:                           is_step_mode = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    mode_d = mode;
                    if (mode == M_LOAD) begin
                        q_d    = d;
                        done_d = 1'b1;
                    end else if (!is_step_mode(mode) || (amount == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        // The accept edge already applies the first step.
                        q_d = step_once(mode, q_q, ser_in_lsb, ser_in_msb);
                        if (amount == CNT_W'(1)) begin
                            done_d = 1'b1;
                        end else begin
                            // Counter holds the number of steps still to apply.
                            cnt_d   = amount - CNT_W'(1);
                            state_d = BUSY;
                            busy_d  = 1'b1;
                        end
                    end
                end
            end

            BUSY: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    q_d   = step_once(mode_q, q_q, ser_in_lsb, ser_in_msb);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            mode_q  <= M_HOLD;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q        = q_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sout_msb = q_q[WIDTH-1];
    assign sout_lsb = q_q[0];

endmodule
